// File: rtl/ub_pkg.sv
// rtl/ub_pkg.sv - shared types and encodings for the unified-buffer FIFO bridge
package ub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_WAIT = 3'd1,
        ST_LD_WR   = 3'd2,
        ST_LD_ACK  = 3'd3,
        ST_DP_RD   = 3'd4,
        ST_DP_ACK  = 3'd5,
        ST_DP_SEND = 3'd6,
        ST_FINISH  = 3'd7
    } bridge_state_e;

    localparam logic DIR_LOAD = 1'b0;
    localparam logic DIR_DUMP = 1'b1;

    localparam logic SEC_LO = 1'b0;
    localparam logic SEC_HI = 1'b1;

endpackage

// File: rtl/ub_done_watchdog.sv
// rtl/ub_done_watchdog.sv - bounded wait counter for the buffer's done acknowledge
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clear_i     restart the count (held during the strobe cycle)
//   count_i     count one waiting cycle
//   expired_o   high in the DONE_TIMEOUT-th consecutive waiting cycle
module ub_done_watchdog #(
    parameter int DONE_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(DONE_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q is the number of waiting cycles already spent, so the
    // DONE_TIMEOUT-th waiting cycle is the one that sees LAST.
    assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/ub_fifo_bridge.sv
// rtl/ub_fifo_bridge.sv - moves 16-bit words between the RX/TX byte streams and the unified buffer
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only when idle)
//   cmd_dir, cmd_base_addr, cmd_len    0 = load, 1 = dump; first word; word count
//   rx_data/rx_valid/rx_ready          incoming byte stream (load)
//   tx_data/tx_valid/tx_ready          outgoing byte stream (dump)
//   ub_we, ub_re, ub_fifo_en           buffer strobes and FIFO-path select
//   ub_section, ub_address             byte lane (0 = low) and word address
//   ub_fifo_in, ub_fifo_out, ub_done   write byte, read byte, one-cycle ack
//   busy, done, err                    status; err is meaningful with done
module ub_fifo_bridge
    import ub_pkg::*;
#(
    parameter int BUFFER_SIZE     = 1024,
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int ADDRESS_SIZE    = $clog2(BUFFER_SIZE),
    parameter int DONE_TIMEOUT    = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_dir,
    input  logic [ADDRESS_SIZE-1:0]    cmd_base_addr,
    input  logic [ADDRESS_SIZE:0]      cmd_len,
    input  logic [FIFO_DATA_WIDTH-1:0] rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [FIFO_DATA_WIDTH-1:0] tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       ub_we,
    output logic                       ub_re,
    output logic                       ub_fifo_en,
    output logic                       ub_section,
    output logic [ADDRESS_SIZE-1:0]    ub_address,
    output logic [FIFO_DATA_WIDTH-1:0] ub_fifo_in,
    input  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_out,
    input  logic                       ub_done,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam logic [ADDRESS_SIZE-1:0] ADDR_LAST = ADDRESS_SIZE'(BUFFER_SIZE - 1);

    bridge_state_e               state_q, state_d;
    logic [ADDRESS_SIZE:0]       len_q, len_d;
    logic [ADDRESS_SIZE:0]       word_cnt_q, word_cnt_d;
    logic                        sec_q, sec_d;
    logic [ADDRESS_SIZE-1:0]     addr_q, addr_d;
    logic [FIFO_DATA_WIDTH-1:0]  fifo_in_q, fifo_in_d;
    logic [FIFO_DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                        err_q, err_d;

    logic                        wd_expired;
    logic [ADDRESS_SIZE:0]       word_inc;
    logic [ADDRESS_SIZE-1:0]     addr_inc;
    logic                        xfer_last;

    ub_done_watchdog #(
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   ((state_q == ST_LD_WR) || (state_q == ST_DP_RD)),
        .count_i   ((state_q == ST_LD_ACK) || (state_q == ST_DP_ACK)),
        .expired_o (wd_expired)
    );

    // Advance bookkeeping: a word is finished only once its high byte moves.
    assign word_inc  = word_cnt_q + (ADDRESS_SIZE + 1)'(1);
    assign addr_inc  = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDRESS_SIZE'(1);
    assign xfer_last = (sec_q == SEC_HI) && (word_inc == len_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            sec_q      <= SEC_LO;
            addr_q     <= '0;
            fifo_in_q  <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            sec_q      <= sec_d;
            addr_q     <= addr_d;
            fifo_in_q  <= fifo_in_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        sec_d      = sec_q;
        addr_d     = addr_q;
        fifo_in_d  = fifo_in_q;
        tx_data_d  = tx_data_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    len_d      = cmd_len;
                    word_cnt_d = '0;
                    sec_d      = SEC_LO;
                    addr_d     = cmd_base_addr;
                    err_d      = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = ST_FINISH;
                    end else if (cmd_dir == DIR_DUMP) begin
                        state_d = ST_DP_RD;
                    end else begin
                        state_d = ST_LD_WAIT;
                    end
                end
            end
            ST_LD_WAIT: begin
                if (rx_valid) begin
                    fifo_in_d = rx_data;
                    state_d   = ST_LD_WR;
                end
            end
            ST_LD_WR: state_d = ST_LD_ACK;
            ST_LD_ACK: begin
                // A done arriving in the last allowed cycle still wins over the timeout.
                if (ub_done) begin
                    if (sec_q == SEC_LO) begin
                        sec_d = SEC_HI;
                    end else begin
                        sec_d      = SEC_LO;
                        addr_d     = addr_inc;
                        word_cnt_d = word_inc;
                    end
                    state_d = xfer_last ? ST_FINISH : ST_LD_WAIT;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_DP_RD: state_d = ST_DP_ACK;
            ST_DP_ACK: begin
                if (ub_done) begin
                    tx_data_d = ub_fifo_out;
                    state_d   = ST_DP_SEND;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_DP_SEND: begin
                if (tx_ready) begin
                    if (sec_q == SEC_LO) begin
                        sec_d = SEC_HI;
                    end else begin
                        sec_d      = SEC_LO;
                        addr_d     = addr_inc;
                        word_cnt_d = word_inc;
                    end
                    state_d = xfer_last ? ST_FINISH : ST_DP_RD;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Every output is a decode of registered state or a register itself.
    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        rx_ready   = (state_q == ST_LD_WAIT);
        tx_valid   = (state_q == ST_DP_SEND);
        ub_we      = (state_q == ST_LD_WR);
        ub_re      = (state_q == ST_DP_RD);
        ub_fifo_en = (state_q == ST_LD_WR) || (state_q == ST_DP_RD);
        done       = (state_q == ST_FINISH);
        err        = err_q;
        tx_data    = tx_data_q;
        ub_fifo_in = fifo_in_q;
        ub_section = sec_q;
        ub_address = addr_q;
    end

endmodule

// File: tb/tb_ub_fifo_bridge.sv
// tb/tb_ub_fifo_bridge.sv - directed self-checking bench for ub_fifo_bridge
module tb_ub_fifo_bridge;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          ub_we, ub_re, ub_fifo_en, ub_section;
    logic [AW-1:0] ub_address;
    logic [7:0]    ub_fifo_in;
    logic [7:0]    ub_fifo_out = '0;
    logic          ub_done = 1'b0;
    logic          busy, done, err;

    logic [9:0]    ov;
    assign ov = {cmd_ready, rx_ready, tx_valid, ub_we, ub_re, ub_fifo_en, ub_section, busy, done, err};

    ub_fifo_bridge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dir       (cmd_dir),
        .cmd_base_addr (cmd_base_addr),
        .cmd_len       (cmd_len),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .ub_we         (ub_we),
        .ub_re         (ub_re),
        .ub_fifo_en    (ub_fifo_en),
        .ub_section    (ub_section),
        .ub_address    (ub_address),
        .ub_fifo_in    (ub_fifo_in),
        .ub_fifo_out   (ub_fifo_out),
        .ub_done       (ub_done),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Buffer model: 16-bit words, byte lanes, ack one cycle after a strobe.
    logic [15:0] mem [0:1023];
    int mstrobe = 0;
    int suppress_at = 0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ub_done <= 1'b0;
        if (ub_we || ub_re) begin
            mstrobe <= mstrobe + 1;
            if (mstrobe + 1 != suppress_at) ub_done <= 1'b1;
            if (ub_we) begin
                if (ub_section) mem[ub_address][15:8] <= ub_fifo_in;
                else            mem[ub_address][7:0]  <= ub_fifo_in;
            end
            if (ub_re) ub_fifo_out <= ub_section ? mem[ub_address][15:8] : mem[ub_address][7:0];
        end
    end

    // RX source: bytes written by the stimulus, consumed on handshake.
    logic [7:0] rx_buf [0:63];
    int rx_wr = 0;
    int rx_rd = 0;

    always @(posedge clk) begin
        if (rx_valid && rx_ready) begin
            rx_rd    <= rx_rd + 1;
            rx_valid <= (rx_rd + 1 != rx_wr);
            rx_data  <= rx_buf[(rx_rd + 1) % 64];
        end else begin
            rx_valid <= (rx_rd != rx_wr);
            rx_data  <= rx_buf[rx_rd % 64];
        end
    end

    // TX sink log.
    logic [7:0] txlog [0:63];
    int tx_n = 0;

    always @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            txlog[tx_n % 64] <= tx_data;
            tx_n             <= tx_n + 1;
        end
    end

    // Observation log sampled mid-cycle.
    int done_cnt = 0, done_cyc = 0, we_cnt = 0, re_cnt = 0, stb_n = 0;
    logic err_at_done = 1'b0;
    int wr_log [0:255];
    int strobe_cyc [0:255];

    always @(negedge clk) begin
        if (done) begin
            done_cnt    <= done_cnt + 1;
            done_cyc    <= cyc;
            err_at_done <= err;
        end
        if (ub_we) begin
            wr_log[we_cnt % 256] <= int'({ub_address, ub_section});
            we_cnt               <= we_cnt + 1;
        end
        if (ub_re) re_cnt <= re_cnt + 1;
        if (ub_we || ub_re) begin
            strobe_cyc[stb_n % 256] <= cyc;
            stb_n                   <= stb_n + 1;
        end
    end

    task automatic push_rx(input logic [7:0] b);
        rx_buf[rx_wr % 64] = b;
        rx_wr = rx_wr + 1;
    endtask

    int t_issue = 0;

    task automatic issue(input logic dir, input int base, input int len);
        int k;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid     = 1'b1;
        cmd_dir       = dir;
        cmd_base_addr = AW'(base);
        cmd_len       = (AW + 1)'(len);
        t_issue       = cyc;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check(tag, done_cnt - d0, 1);
    endtask

    int d0, w0, r0, t0, s0;

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_flags", {22'd0, ov}, 32'h200);
        check("reset_addr", {22'd0, ub_address}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Load base 10, two words.
        d0 = done_cnt; w0 = we_cnt; r0 = re_cnt;
        push_rx(8'h34); push_rx(8'h12); push_rx(8'h78); push_rx(8'h56);
        issue(1'b0, 10, 2);
        wait_done("load_done", d0);
        check("load_err", {31'd0, err_at_done}, 32'd0);
        check("load_we_cnt", we_cnt - w0, 4);
        check("load_re_cnt", re_cnt - r0, 0);
        for (int i = 0; i < 4; i++) check("load_wr_addr_sec", wr_log[w0 + i], 20 + i);
        check("load_mem10", {16'd0, mem[10]}, 32'h1234);
        check("load_mem11", {16'd0, mem[11]}, 32'h5678);
        repeat (3) @(negedge clk);
        #1;
        check("load_done_once", done_cnt - d0, 1);

        // Put 0xBEEF at word 5, then dump it with tx_ready high.
        d0 = done_cnt;
        push_rx(8'hEF); push_rx(8'hBE);
        issue(1'b0, 5, 1);
        wait_done("prep_done", d0);
        d0 = done_cnt; t0 = tx_n; r0 = re_cnt;
        tx_ready = 1'b1;
        issue(1'b1, 5, 1);
        wait_done("dump_done", d0);
        check("dump_tx_cnt", tx_n - t0, 2);
        check("dump_byte0", {24'd0, txlog[t0 % 64]}, 32'hEF);
        check("dump_byte1", {24'd0, txlog[(t0 + 1) % 64]}, 32'hBE);
        check("dump_re_cnt", re_cnt - r0, 2);

        // Dump word 10 with the TX side stalled for 7 cycles.
        d0 = done_cnt; t0 = tx_n;
        tx_ready = 1'b0;
        issue(1'b1, 10, 1);
        for (int k = 0; k < 50 && !tx_valid; k++) begin
            @(negedge clk); #1;
        end
        r0 = re_cnt;
        for (int k = 0; k < 7; k++) begin
            check("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
            check("stall_tx_data", {24'd0, tx_data}, 32'h34);
            @(negedge clk); #1;
        end
        check("stall_no_extra_re", re_cnt - r0, 0);
        tx_ready = 1'b1;
        wait_done("stall_done", d0);
        check("stall_byte0", {24'd0, txlog[t0 % 64]}, 32'h34);
        check("stall_byte1", {24'd0, txlog[(t0 + 1) % 64]}, 32'h12);

        // Load across the top of the buffer.
        d0 = done_cnt; w0 = we_cnt;
        push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_rx(8'h44);
        issue(1'b0, 1023, 2);
        wait_done("wrap_done", d0);
        check("wrap_last_wr", wr_log[(w0 + 3) % 256], 1);
        check("wrap_mem1023", {16'd0, mem[1023]}, 32'h2211);
        check("wrap_mem0", {16'd0, mem[0]}, 32'h4433);
        @(negedge clk); #1;
        check("wrap_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Third strobe never acknowledged -> timeout.
        d0 = done_cnt; w0 = we_cnt; s0 = stb_n;
        suppress_at = mstrobe + 3;
        push_rx(8'hAA); push_rx(8'hBB); push_rx(8'hCC);
        issue(1'b0, 20, 2);
        wait_done("timeout_done", d0);
        check("timeout_err", {31'd0, err_at_done}, 32'd1);
        check("timeout_latency", done_cyc - strobe_cyc[(s0 + 2) % 256], 16);
        check("timeout_we_cnt", we_cnt - w0, 3);
        check("timeout_mem20", {16'd0, mem[20]}, 32'hBBAA);
        suppress_at = 0;

        // Zero-length command right after the timeout.
        @(negedge clk); #1;
        d0 = done_cnt; w0 = we_cnt; r0 = re_cnt;
        issue(1'b1, 7, 0);
        wait_done("len0_done", d0);
        check("len0_latency", done_cyc - t_issue, 1);
        check("len0_err_cleared", {31'd0, err_at_done}, 32'd0);
        check("len0_no_strobes", (we_cnt - w0) + (re_cnt - r0), 0);

        // Reset in the middle of a load.
        push_rx(8'h5A);
        issue(1'b0, 30, 2);
        repeat (6) @(negedge clk);
        #1;
        check("midload_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("midreset_flags", {22'd0, ov}, 32'h200);
        check("midreset_addr", {22'd0, ub_address}, 32'd0);
        check("midreset_fifo_in", {24'd0, ub_fifo_in}, 32'd0);
        check("midreset_tx_data", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
